inout_combine: RTL and testbench

Parametrised N-channel, W-bit join-and-combine stage. Waits until every enabled input channel presents valid data, then folds the channels into one word with a selectable bitwise reduction (OR/AND/XOR). It optionally accumulates that word over several accepted beats before presenting one registered result on a valid/ready output. It sits between independent producer lanes and a single consumer, and replaces fixed two-input OR glue.

---
 rtl/inout_combine_pkg.sv | 32 +++
 rtl/inout_combine_reduce.sv | 27 ++
 rtl/inout_combine.sv | 115 +++++++++++
 tb/tb_inout_combine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/inout_combine_pkg.sv
// Shared types and helpers for the inout_combine join-and-combine stage.
package inout_combine_pkg;

  localparam int ID_W = 256;

  typedef enum logic [1:0] {
    MODE_OR  = 2'd0,
    MODE_AND = 2'd1,
    MODE_XOR = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Raw mode code 3 is a reserved alias of OR.
  function automatic mode_e to_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_AND;
      2'd2:    return MODE_XOR;
      default: return MODE_OR;
    endcase
  endfunction

  // Identity element of the reduction; callers size-cast down to their width.
  function automatic logic [ID_W-1:0] identity(input mode_e m);
    return (m == MODE_AND) ? '1 : '0;
  endfunction

endpackage

// File: rtl/inout_combine_reduce.sv
// Combinational bitwise reduction of the enabled channels of a packed word.
module inout_combine_reduce
  import inout_combine_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  mode_e                  mode,
  input  logic [NCH-1:0]         chan_en,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]       beat
);

  always_comb begin
    beat = WIDTH'(identity(mode));
    for (int i = 0; i < NCH; i++) begin
      if (chan_en[i]) begin
        case (mode)
          MODE_AND: beat = beat & in_data[i*WIDTH +: WIDTH];
          MODE_XOR: beat = beat ^ in_data[i*WIDTH +: WIDTH];
          default:  beat = beat | in_data[i*WIDTH +: WIDTH];
        endcase
      end
    end
  end

endmodule

// File: rtl/inout_combine.sv
// N-channel join, bitwise combine and optional multi-beat accumulation with
// a registered valid/ready result.
module inout_combine
  import inout_combine_pkg::*;
#(
  parameter int  WIDTH   = 8,
  parameter int  NCH     = 2,
  parameter int  ACC_MAX = 16,
  localparam int CW      = $clog2(ACC_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [NCH-1:0]       chan_en,
  input  logic [CW-1:0]        acc_len,
  input  logic                 flush,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CW-1:0]        out_beats,
  output logic                 busy
);

  state_e           state, state_n;
  logic [WIDTH-1:0] acc_p1, acc_n;
  logic [CW-1:0]    cnt_p1, cnt_n;
  logic [CW-1:0]    tgt_p1, tgt_n;
  mode_e            mode_p1, mode_n;

  logic             join_ok, can_accept, accept;
  logic [CW-1:0]    eff_len, cnt_inc;
  mode_e            beat_mode;
  logic [WIDTH-1:0] beat, folded;

  assign join_ok    = (&(in_valid | ~chan_en)) & (|chan_en);
  assign can_accept = (state != HOLD) | out_ready;
  assign accept     = join_ok & can_accept;
  assign in_ready   = rst ? '0 : (chan_en & {NCH{accept}});

  assign eff_len = (acc_len == '0)             ? CW'(1) :
                   (acc_len > CW'(ACC_MAX))    ? CW'(ACC_MAX) : acc_len;
  assign cnt_inc = cnt_p1 + CW'(1);

  // Mid-group beats use the latched mode; a group's first beat uses the live one.
  assign beat_mode = (state == ACCUM) ? mode_p1 : to_mode(mode);

  inout_combine_reduce #(.WIDTH(WIDTH), .NCH(NCH)) u_beat (
    .mode    (beat_mode),
    .chan_en (chan_en),
    .in_data (in_data),
    .beat    (beat)
  );

  inout_combine_reduce #(.WIDTH(WIDTH), .NCH(2)) u_fold (
    .mode    (mode_p1),
    .chan_en (2'b11),
    .in_data ({beat, acc_p1}),
    .beat    (folded)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc_p1;
    cnt_n   = cnt_p1;
    tgt_n   = tgt_p1;
    mode_n  = mode_p1;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_n = folded;
          cnt_n = cnt_inc;
          if (cnt_inc == tgt_p1) state_n = HOLD;
        end
        if (flush) state_n = HOLD;
      end
      default: begin
        if (accept) begin
          acc_n   = beat;
          cnt_n   = CW'(1);
          tgt_n   = eff_len;
          mode_n  = to_mode(mode);
          state_n = (eff_len == CW'(1)) ? HOLD : ACCUM;
        end else if (state == HOLD && out_ready) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  // Stage p1: group state, accumulator and the registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc_p1  <= '0;
      cnt_p1  <= '0;
      tgt_p1  <= '0;
      mode_p1 <= MODE_OR;
    end else begin
      state   <= state_n;
      acc_p1  <= acc_n;
      cnt_p1  <= cnt_n;
      tgt_p1  <= tgt_n;
      mode_p1 <= mode_n;
    end
  end

  assign out_valid = (state == HOLD);
  assign out_data  = acc_p1;
  assign out_beats = cnt_p1;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inout_combine.sv
// Randomized and directed bench for inout_combine against a transaction model.
module tb_inout_combine;

  localparam int WIDTH = 8;
  localparam int NCH = 2;
  localparam int ACC_MAX = 16;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = '0;
  logic [NCH-1:0]   chan_en = '0;
  logic [CW-1:0]    acc_len = '0;
  logic             flush = 1'b0;
  logic [NCH-1:0]   in_valid = '0;
  logic [NCH-1:0]   in_ready;
  logic [2*WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_beats;
  logic             busy;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: group open / result pending plus arithmetic contents.
  bit   m_open, m_pend;
  logic [7:0] m_acc;
  int   m_cnt, m_tgt, m_mode;
  logic [7:0] held_data;

  inout_combine #(.WIDTH(WIDTH), .NCH(NCH), .ACC_MAX(ACC_MAX)) dut (
    .clk(clk), .rst(rst), .mode(mode), .chan_en(chan_en), .acc_len(acc_len),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] op(input int md, input logic [7:0] a, input logic [7:0] b);
    if (md == 1) return a & b;
    if (md == 2) return a ^ b;
    return a | b;
  endfunction

  function automatic int norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? 0 : int'(m);
  endfunction

  function automatic logic [7:0] reduce(input int md, input logic [1:0] en, input logic [15:0] d);
    logic [7:0] r;
    r = (md == 1) ? 8'hFF : 8'h00;
    for (int i = 0; i < 2; i++)
      if (en[i]) r = op(md, r, d[i*8 +: 8]);
    return r;
  endfunction

  task automatic model_reset();
    m_open = 0; m_pend = 0; m_acc = '0; m_cnt = 0; m_tgt = 0; m_mode = 0;
  endtask

  task automatic start_group();
    int len;
    len = int'(acc_len);
    if (len == 0) len = 1;
    if (len > ACC_MAX) len = ACC_MAX;
    m_mode = norm_mode(mode);
    m_tgt = len;
    m_acc = reduce(m_mode, chan_en, in_data);
    m_cnt = 1;
    m_pend = (len == 1);
    m_open = (len != 1);
  endtask

  // Check current outputs and handshake, advance the model, move to next cycle.
  task automatic cycle();
    bit jn, can, ok;
    #1;
    jn = ((in_valid | ~chan_en) == 2'b11) && (chan_en != 2'b00);
    can = !m_pend || out_ready;
    ok = jn && can;
    chk("in_ready", in_ready, ok ? chan_en : 2'b00);
    chk("out_valid", out_valid, m_pend);
    chk("busy", busy, m_pend || m_open);
    if (m_pend) begin
      chk("out_data", out_data, m_acc);
      chk("out_beats", out_beats, m_cnt);
    end
    if (m_open) begin
      if (ok) begin
        m_acc = op(m_mode, m_acc, reduce(m_mode, chan_en, in_data));
        m_cnt++;
        if (m_cnt == m_tgt) begin m_open = 0; m_pend = 1; end
      end
      if (flush && m_open) begin m_open = 0; m_pend = 1; end
    end else if (ok) begin
      start_group();
    end else if (m_pend && out_ready) begin
      m_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_beats", out_beats, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic [1:0] md, input logic [1:0] en, input logic [4:0] len,
                       input logic [1:0] vld, input logic [7:0] d1, input logic [7:0] d0,
                       input logic ord, input logic fl);
    mode = md; chan_en = en; acc_len = len; in_valid = vld;
    in_data = {d1, d0}; out_ready = ord; flush = fl;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // OR single beat
    drive(2'd0, 2'b11, 5'd1, 2'b11, 8'hA0, 8'h0F, 1'b1, 1'b0);
    cycle();
    chk("t1_data", out_data, 8'hAF);
    chk("t1_beats", out_beats, 5'd1);
    drive(2'd0, 2'b11, 5'd1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle();

    // Join stall
    for (int i = 0; i < 3; i++) begin
      drive(2'd0, 2'b11, 5'd1, 2'b01, 8'h11, 8'h22, 1'b1, 1'b0);
      cycle();
    end
    drive(2'd0, 2'b11, 5'd1, 2'b11, 8'h11, 8'h22, 1'b1, 1'b0);
    cycle();
    chk("stall_data", out_data, 8'h33);
    drive(2'd0, 2'b11, 5'd1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle();

    // AND with ch1 disabled
    drive(2'd1, 2'b01, 5'd1, 2'b11, 8'h00, 8'h3C, 1'b1, 1'b0);
    #1 chk("and_ready", in_ready, 2'b01);
    cycle();
    chk("and_data", out_data, 8'h3C);
    drive(2'd1, 2'b01, 5'd1, 2'b00, 8'h00, 8'h3C, 1'b1, 1'b0);
    cycle();

    // XOR over 3 beats, mode change mid-group ignored
    drive(2'd2, 2'b11, 5'd3, 2'b11, 8'h02, 8'h01, 1'b1, 1'b0);
    cycle();
    drive(2'd0, 2'b11, 5'd3, 2'b11, 8'h00, 8'h04, 1'b1, 1'b0);
    cycle();
    chk("xor_not_yet", out_valid, 1'b0);
    drive(2'd0, 2'b11, 5'd3, 2'b11, 8'h10, 8'h10, 1'b0, 1'b0);
    cycle();
    chk("xor_data", out_data, 8'h07);
    chk("xor_beats", out_beats, 5'd3);

    // Backpressure then drain with a coincident beat
    drive(2'd0, 2'b11, 5'd1, 2'b11, 8'h40, 8'h08, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("bp_stable", out_data, 8'h07);
    drive(2'd0, 2'b11, 5'd1, 2'b11, 8'h40, 8'h08, 1'b1, 1'b0);
    cycle();
    chk("bp_newdata", out_data, 8'h48);
    drive(2'd0, 2'b11, 5'd1, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle();

    // Flush after two of four beats
    drive(2'd0, 2'b11, 5'd4, 2'b11, 8'h00, 8'h01, 1'b1, 1'b0);
    cycle();
    drive(2'd0, 2'b11, 5'd4, 2'b11, 8'h00, 8'h02, 1'b1, 1'b0);
    cycle();
    drive(2'd0, 2'b11, 5'd4, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    cycle();
    chk("flush_data", out_data, 8'h03);
    chk("flush_beats", out_beats, 5'd2);
    drive(2'd0, 2'b11, 5'd4, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle();

    // Reset mid-group discards the partial result
    drive(2'd0, 2'b11, 5'd4, 2'b11, 8'h00, 8'h05, 1'b1, 1'b0);
    cycle();
    cycle();
    drive(2'd0, 2'b11, 5'd4, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] en;
      logic [4:0] len;
      en = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
      len = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
      drive(2'($urandom), en, len, ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11,
            8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
